// File: rtl/bitstream_window.sv
// Bit-aligning MSB-first shift buffer feeding the unary/run-length priority encoder; optional stats via BITSTREAM_WINDOW_STATS_EN.
// Latency: a push or consume is visible on the window outputs one cycle later; outputs come from registers only.
// Backpressure: in_ready drops when the registered level leaves no room for a word, or once the last word is in (DRAIN/DONE).
module bitstream_window #(
  parameter int IN_W  = 32,
  parameter int WIN_W = 16,
  parameter int BUF_W = 64,
  parameter int CNT_W = $clog2(WIN_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIN_W-1:0] win_data,
  output logic [CNT_W-1:0] win_avail,
  output logic             win_valid,
  input  logic             consume_en,
  input  logic [CNT_W-1:0] consume_cnt,
  input  logic             flush,
  output logic             done,
  output logic             err_overconsume
`ifdef BITSTREAM_WINDOW_STATS_EN
  ,
  output logic [31:0]      bits_consumed,
  output logic [31:0]      words_accepted
`endif
);

  localparam int LVL_W = $clog2(BUF_W + 1);
  localparam logic [LVL_W-1:0] WIN_LVL   = LVL_W'(WIN_W);
  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_W);
  localparam logic [LVL_W-1:0] ROOM_LVL  = LVL_W'(BUF_W - IN_W);
  localparam logic [LVL_W-1:0] WORD_LVL  = LVL_W'(IN_W);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] sreg_q, sreg_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             err_q;

  logic             push;
  logic             over;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] eff;
  logic [LVL_W-1:0] lvl_mid;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] word_ext;

  // Window occupancy and acceptance, derived only from registered state.
  always_comb begin
    avail    = (level_q >= WIN_LVL) ? WIN_CNT : level_q[CNT_W-1:0];
    in_ready = (state_q != ST_DRAIN) && (state_q != ST_DONE) && (level_q <= ROOM_LVL);
    push     = in_valid && in_ready;
    over     = consume_en && (consume_cnt > avail);
    eff      = '0;
    if (consume_en) begin
      eff = over ? avail : consume_cnt;
    end
  end

  // Datapath: drop consumed bits first, then land the new word right behind what is left.
  // Bits below the valid level are always zero, so OR-ing the aligned word is enough.
  always_comb begin
    lvl_mid  = level_q - LVL_W'(eff);
    shifted  = sreg_q << eff;
    word_ext = {in_data, {(BUF_W - IN_W){1'b0}}} >> lvl_mid;
    sreg_d   = shifted;
    level_d  = lvl_mid;
    if (push) begin
      sreg_d  = shifted | word_ext;
      level_d = lvl_mid + WORD_LVL;
    end
  end

  // Stream phase: a word flagged last (even the very first) ends acceptance; DONE waits for flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = in_last ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push && in_last) begin
          state_d = ST_DRAIN;
        end else if (!push && (level_d == '0)) begin
          state_d = ST_EMPTY;
        end
      end
      ST_DRAIN: begin
        if (level_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, buffer, level and sticky error registers; flush clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sreg_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      sreg_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      level_q <= level_d;
      if (over) begin
        err_q <= 1'b1;
      end
    end
  end

  // Registered-only window view for the encoder.
  always_comb begin
    win_data        = sreg_q[BUF_W-1 -: WIN_W];
    win_avail       = avail;
    win_valid       = (level_q >= WIN_LVL) || ((state_q == ST_DRAIN) && (level_q != '0));
    done            = (state_q == ST_DONE);
    err_overconsume = err_q;
  end

`ifdef BITSTREAM_WINDOW_STATS_EN
  logic [31:0] bits_q;
  logic [31:0] words_q;
  logic [32:0] bits_sum;

  // Saturating sum of bits actually removed from the window.
  always_comb begin
    bits_sum = {1'b0, bits_q} + 33'(eff);
  end

  // Saturating throughput counters, cleared alongside the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q  <= '0;
      words_q <= '0;
    end else if (flush) begin
      bits_q  <= '0;
      words_q <= '0;
    end else begin
      bits_q <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
      if (push && (words_q != 32'hFFFF_FFFF)) begin
        words_q <= words_q + 32'd1;
      end
    end
  end

  assign bits_consumed  = bits_q;
  assign words_accepted = words_q;
`endif

endmodule
